// File: rtl/expansion_xor_stage.sv
// expansion_xor_stage
// Generalised DES E expansion with optional subkey XOR, followed by an
// elastic FIFO with valid/ready on both sides. The FIFO decouples the
// R-half register from the S-box stage so downstream stalls never reach
// back combinationally through this block.
module expansion_xor_stage #(
  parameter int GROUPS = 8,
  parameter int DEPTH  = 2,
  localparam int W     = 4 * GROUPS,
  localparam int X     = 6 * GROUPS,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:W-1]  in_data,
  input  logic [0:X-1]  in_key,
  input  logic          in_key_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:X-1]  out_data,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [0:X-1]  expanded;
  logic [0:X-1]  keyed;
  logic [0:X-1]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_r;
  logic          push;
  logic          pop;

  // Each 4-bit group borrows its left neighbour's last bit and its right
  // neighbour's first bit; indices wrap around the half-block.
  for (genvar g = 0; g < GROUPS; g++) begin : g_expand
    assign expanded[6*g]         = in_data[(4*g + W - 1) % W];
    assign expanded[6*g+1 +: 4]  = in_data[4*g +: 4];
    assign expanded[6*g+5]       = in_data[(4*g + 4) % W];
  end

  // Key is mixed in at the accept edge, sampled together with the data.
  assign keyed = expanded ^ (in_key_en ? in_key : '0);

  // Handshake qualifiers; reset blocks both directions in its own cycle.
  assign in_ready  = !rst && (level_r < DEPTH_L);
  assign out_valid = (level_r != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !rst;

  // Head of queue is presented only when valid so idle output reads zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    out_data = '0;
    if (out_valid) out_data = mem[rd_ptr];
  end

  // Storage array: written on push only.
  // NOTE: the payload array is deliberately not reset; occupancy is
  // tracked by level/pointers, and stale entries are never presented
  // because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= keyed;
  end

  // Pointer and occupancy bookkeeping with synchronous flush.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops
    // update from pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_P;
      if (pop)  rd_ptr <= rd_ptr + ONE_P;
      case ({push, pop})
        2'b10:   level_r <= level_r + ONE_L;
        2'b01:   level_r <= level_r - ONE_L;
        default: level_r <= level_r;
      endcase
    end
  end

  assign level = level_r;

endmodule

// File: tb/tb_expansion_xor_stage.sv
// Scoreboard bench for expansion_xor_stage: a GROUPS=8 (DES) instance and a
// GROUPS=2 instance. Drivers push expected words when a transfer is accepted;
// monitors pop and compare whenever an output transfer takes place.
module tb_expansion_xor_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // GROUPS = 8 instance
  logic        in_valid8 = 1'b0, in_ready8, in_key_en8 = 1'b0;
  logic [0:31] in_data8 = '0;
  logic [0:47] in_key8 = '0, out_data8;
  logic        out_valid8, out_ready8 = 1'b0;
  logic [1:0]  level8;

  // GROUPS = 2 instance
  logic        in_valid2 = 1'b0, in_ready2, in_key_en2 = 1'b0;
  logic [0:7]  in_data2 = '0;
  logic [0:11] in_key2 = '0, out_data2;
  logic        out_valid2, out_ready2 = 1'b0;
  logic [1:0]  level2;

  expansion_xor_stage #(.GROUPS(8), .DEPTH(2)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_key(in_key8), .in_key_en(in_key_en8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .level(level8)
  );

  expansion_xor_stage #(.GROUPS(2), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .in_key(in_key2), .in_key_en(in_key_en2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .level(level2)
  );

  int n_vec = 0;
  int n_err = 0;
  int popped8 = 0;
  bit streaming = 1'b0;
  logic [0:47] q8[$];
  logic [0:11] q2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: output bit j of group j/6 takes input bit 4*(j/6)+(j%6)-1 mod 32.
  function automatic logic [0:47] model8(input logic [0:31] d, input logic [0:47] k,
                                         input logic en);
    logic [0:47] e;
    for (int j = 0; j < 48; j++) e[j] = d[(4 * (j / 6) + (j % 6) - 1 + 32) % 32];
    return en ? (e ^ k) : e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send8(input logic [0:31] d, input logic [0:47] k, input logic en,
                       input logic [0:47] exp);
    bit done = 1'b0;
    in_valid8 = 1'b1; in_data8 = d; in_key8 = k; in_key_en8 = en;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready8) begin
        q8.push_back(exp);
        done = 1'b1;
      end else if (streaming) begin
        n_vec++; n_err++;
        $display("FAIL stream_in_ready: got 0, expected 1");
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send8_timeout: got no accept, expected accept within 50 cycles");
    end
  endtask

  task automatic send2(input logic [0:7] d, input logic [0:11] exp);
    bit done = 1'b0;
    in_valid2 = 1'b1; in_data2 = d; in_key2 = '0; in_key_en2 = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready2) begin
        q2.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send2_timeout: got no accept, expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && (q8.size() != 0 || q2.size() != 0); c++) @(posedge clk);
    #1;
  endtask

  // Monitor for the GROUPS=8 instance.
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out8_unexpected: got %h, expected no word", out_data8);
      end else begin
        check("out8_data", 64'(out_data8), 64'(q8.pop_front()));
        popped8++;
      end
    end
    if (streaming) check("stream_level_le1", 64'(level8 <= 2'd1), 64'd1);
  end

  // Monitor for the GROUPS=2 instance.
  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out2_unexpected: got %h, expected no word", out_data2);
      end else begin
        check("out2_data", 64'(out_data2), 64'(q2.pop_front()));
      end
    end
  end

  initial begin
    logic [0:31] d;
    logic [0:47] k;
    logic        en;
    int          start_pops;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_level", 64'(level8), 64'd0);
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_out_data", 64'(out_data8), 64'd0);
    check("rst_in_ready", 64'(in_ready8), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;

    // DES vectors and wrap bits
    out_ready8 = 1'b1;
    send8(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0, 48'h7A15557A1555);
    send8(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 48'h6117BA866527);
    send8(32'h00000001, 48'h0, 1'b0, 48'h800000000002);
    send8(32'h80000000, 48'h0, 1'b0, 48'h400000000001);
    send8(32'hFFFFFFFF, 48'h0, 1'b0, 48'hFFFFFFFFFFFF);
    in_valid8 = 1'b0;

    // Generic width
    out_ready2 = 1'b1;
    send2(8'h01, 12'h802);
    send2(8'h80, 12'h401);
    in_valid2 = 1'b0;
    drain();
    @(negedge clk);
    check("empty_out_data", 64'(out_data8), 64'd0);
    @(posedge clk); #1;

    // Full / backpressure: A, B accepted, C held until a pop frees a slot
    out_ready8 = 1'b0;
    send8(32'h00000001, 48'h0, 1'b0, 48'h800000000002);
    send8(32'h80000000, 48'h0, 1'b0, 48'h400000000001);
    in_valid8 = 1'b1; in_data8 = 32'hFFFFFFFF; in_key_en8 = 1'b0;
    @(negedge clk);
    check("full_level", 64'(level8), 64'd2);
    check("full_in_ready", 64'(in_ready8), 64'd0);
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    @(negedge clk);
    check("full_held_level", 64'(level8), 64'd2);
    check("full_no_passthru", 64'(in_ready8), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_pop_level", 64'(level8), 64'd1);
    check("after_pop_in_ready", 64'(in_ready8), 64'd1);
    if (in_ready8) q8.push_back(48'hFFFFFFFFFFFF);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    drain();

    // Streaming: 100 back-to-back random words
    start_pops = popped8;
    streaming = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      k = {16'($urandom), $urandom};
      en = 1'($urandom);
      send8(d, k, en, model8(d, k, en));
    end
    in_valid8 = 1'b0;
    drain();
    streaming = 1'b0;
    check("stream_count", 64'(popped8 - start_pops), 64'd100);

    // Reset mid-flight with a concurrent push
    out_ready8 = 1'b0;
    send8(32'h12345678, 48'h0, 1'b0, model8(32'h12345678, 48'h0, 1'b0));
    send8(32'h9ABCDEF0, 48'h0, 1'b0, model8(32'h9ABCDEF0, 48'h0, 1'b0));
    in_valid8 = 1'b1; in_data8 = 32'hDEADBEEF;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_level_before", 64'(level8), 64'd2);
    check("mid_rst_in_ready", 64'(in_ready8), 64'd0);
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    check("flush_level", 64'(level8), 64'd0);
    check("flush_out_valid", 64'(out_valid8), 64'd0);
    check("flush_out_data", 64'(out_data8), 64'd0);
    check("flush_in_ready", 64'(in_ready8), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    send8(32'hF0AAF0AA, 48'h0, 1'b0, 48'h7A15557A1555);
    in_valid8 = 1'b0;
    drain();

    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/expansion_xor_stage.md
# expansion_xor_stage

Parametrised, elastic successor to the combinational DES expansion permutation. Expands a GROUPS×4-bit half-block to GROUPS×6 bits using the generalised DES E rule. Optionally XORs the result with a round subkey, then queues it in a DEPTH-entry FIFO with valid/ready handshakes on both sides. Sits between the R-half register and the S-box stage of the round datapath, decoupling them so key schedule and S-box stalls do not backpressure combinationally.

## Interface
- GROUPS, 8, number of 4-bit input groups; W = 4*GROUPS input bits, X = 6*GROUPS output bits; legal ≥ 2
- DEPTH, 2, FIFO entries; power of two, ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_key/in_key_en valid
- in_ready  output  1  stage can accept this cycle
- in_data  input  [0:W-1]  half-block; index 0 = MSB
- in_key  input  [0:X-1]  subkey; index 0 = MSB
- in_key_en  input  1  1: XOR in_key; 0: pass expansion unmodified
- out_valid  output  1  out_data holds the FIFO head
- out_ready  input  1  consumer accepts head this cycle
- out_data  output  [0:X-1]  expanded (and keyed) word
- level  output  [$clog2(DEPTH+1)-1:0]  current entry count

## Operation
- Expansion, for group g in 0..GROUPS-1, indices mod W: E[6g] = in_data[4g-1]; E[6g+1..6g+4] = in_data[4g..4g+3]; E[6g+5] = in_data[4g+4].
  - With GROUPS = 8 this is exactly DES E: bit 0 takes in_data[31], bit 47 takes in_data[0].
- Stored word = E ^ (in_key_en ? in_key : 0), computed at the accept edge; the key is sampled together with the data.
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- FIFO is circular, with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0. level tracks occupancy.
- in_ready = !rst & (level < DEPTH). There is no pass-through when full: a same-cycle pop does not enable a push while level == DEPTH.
- out_valid = (level != 0). out_data = head entry when out_valid, else all zeros.
- Simultaneous push and pop at 0 < level < DEPTH: both occur, level unchanged, order preserved.
- Data is strictly FIFO. No word is dropped or duplicated.
- in_valid without in_ready: nothing happens. The source must hold its data (standard valid/ready).
- out_valid, once high, stays high with stable out_data until popped (guaranteed by construction).

## Timing
- Reset, synchronous: level = 0, pointers = 0, out_valid = 0, out_data = 0. in_ready = 0 while rst = 1 and 1 in the first cycle after.
- Reset mid-operation flushes all entries. A push or pop asserted in the same cycle as rst is ignored.
- Latency: a word accepted at edge k appears on out_data with out_valid = 1 after edge k. It can be popped at edge k+1 at the earliest.
- Throughput: 1 word/cycle sustained whenever out_ready = 1.
- Full: level == DEPTH, in_ready = 0 in that cycle. in_ready returns to 1 the cycle after a pop.
- Empty: level == 0, out_valid = 0, out_data = 0. out_ready is ignored.
- level, out_valid and in_ready all derive from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- DES vector: GROUPS = 8, in_data = 32'hF0AAF0AA, in_key_en = 0 -> out_data = 48'h7A15557A1555. With in_key = 48'h1B02EFFC7072 and in_key_en = 1 -> 48'h6117BA866527.
- Wrap bits:
  - in_data = 32'h00000001 -> 48'h800000000002.
  - in_data = 32'h80000000 -> 48'h400000000001.
  - in_data = 32'hFFFFFFFF -> 48'hFFFFFFFFFFFF.
- Generic width: GROUPS = 2, in_data = 8'h01, key disabled -> out_data = 12'h802. in_data = 8'h80 -> 12'h401.
- Full/backpressure: DEPTH = 2, out_ready = 0, push A, B, C on consecutive cycles. Required response:
  - A and B accepted; level = 2; in_ready = 0; C held.
  - Raise out_ready: pops return A then B, then C, in order.
- Streaming: out_ready = 1, push 100 random words back-to-back -> all 100 emerged in order, level ≤ 1 throughout, in_ready never drops.
- Reset mid-flight: level = 2, assert rst for 1 cycle alongside in_valid -> next cycle level = 0, out_valid = 0, out_data = 0, in_ready = 1. The flushed words and the concurrent push never appear on the output.
